// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states and default bus widths.
// Used by apb_master_bridge, the APB slave memory and the bench.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent with PREADY low and flags the abort cycle.
// Only instantiated when APB_MASTER_PREADY_EN is defined.
module apb_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic stall,
   output logic expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   // Wait counter: cleared in SETUP, advances on each stalled ACCESS cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (stall) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Abort on the stalled cycle that would bring the count up to TIMEOUT.
   assign expired_c = (TIMEOUT != 32'd0) && stall &&
                      ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

endmodule

// File: rtl/apb_master_bridge.sv
// Single-channel APB master: valid/ready command port in, APB SETUP/ACCESS
// transfers out, one-cycle response strobe back.
// Optional feature macro: APB_MASTER_PREADY_EN (PREADY port, wait states,
// TIMEOUT abort). Without it ACCESS is always one cycle and rsp_err is 0.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W = APB_ADDR_W,
   parameter int unsigned DATA_W = APB_DATA_W
`ifdef APB_MASTER_PREADY_EN
   ,
   parameter int unsigned TIMEOUT = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA
`ifdef APB_MASTER_PREADY_EN
   ,
   input  logic              PREADY
`endif
);

   apb_state_e        state_q;
   apb_state_e        state_nxt;
   logic              accept_c;
   logic              pready_c;
   logic              timeout_c;
   logic              done_c;

   logic [ADDR_W-1:0] paddr_nxt;
   logic              pwrite_nxt;
   logic [DATA_W-1:0] pwdata_nxt;
   logic              psel_nxt;
   logic              penable_nxt;
   logic              ready_nxt;
   logic              rsp_valid_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              err_nxt;

`ifdef APB_MASTER_PREADY_EN
   assign pready_c = PREADY;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clr       (state_q == SETUP),
      .stall     ((state_q == ACCESS) && !PREADY),
      .expired_c (timeout_c)
   );
`else
   assign pready_c  = 1'b1;
   assign timeout_c = 1'b0;
`endif

   assign accept_c = cmd_valid && cmd_ready && (state_q == IDLE);
   assign done_c   = (state_q == ACCESS) && (pready_c || timeout_c);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state: accept -> SETUP -> ACCESS -> (ready or timeout) -> IDLE.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE:    if (accept_c) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output next-values: bus phase follows next state, cmd captured at accept.
   always_comb begin
      paddr_nxt     = PADDR;
      pwrite_nxt    = PWRITE;
      pwdata_nxt    = PWDATA;
      rdata_nxt     = rsp_rdata;
      err_nxt       = 1'b0;
      psel_nxt      = (state_nxt != IDLE);
      penable_nxt   = (state_nxt == ACCESS);
      ready_nxt     = (state_nxt == IDLE);
      rsp_valid_nxt = done_c;
      if (accept_c) begin
         paddr_nxt  = cmd_addr;
         pwrite_nxt = cmd_write;
         pwdata_nxt = cmd_wdata;
      end
      if (done_c) begin
         err_nxt   = timeout_c;
         rdata_nxt = (!PWRITE && !timeout_c) ? PRDATA : '0;
      end
   end

   // Output registers; reset drops any in-flight transfer silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         PADDR     <= paddr_nxt;
         PWRITE    <= pwrite_nxt;
         PWDATA    <= pwdata_nxt;
         PSEL      <= psel_nxt;
         PENABLE   <= penable_nxt;
         cmd_ready <= ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rdata_nxt;
         rsp_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a behavioural APB slave
// memory and a reference memory model of expected read data.
module tb_apb_master_bridge;
   import apb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        pready_w;

   int n_cmp  = 0;
   int n_fail = 0;
   int rsp_cnt = 0;
   int wait_cfg = 0;
   int wait_used = 0;

   logic [31:0] slave_mem [256];
   logic [31:0] ref_mem   [256];

   always #5 clk = ~clk;

`ifdef APB_MASTER_PREADY_EN
   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
`else
   apb_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA)
`ifdef APB_MASTER_PREADY_EN
      ,
      .PREADY    (pready_w)
`endif
   );

   // Behavioural APB slave: combinational read, write on completed ACCESS.
`ifdef APB_MASTER_PREADY_EN
   assign pready_w = (wait_used >= wait_cfg);
`else
   assign pready_w = 1'b1;
`endif
   assign PRDATA = slave_mem[PADDR[7:0]];

   always @(posedge clk) begin
      if (PSEL && PENABLE && PWRITE && pready_w) slave_mem[PADDR[7:0]] <= PWDATA;
      if (PSEL && PENABLE) wait_used <= wait_used + 1;
      else wait_used <= 0;
   end

   always @(negedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One command through the bridge; returns response and accept-to-response latency.
   task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, output logic [31:0] rdata, output logic err,
                          output int lat);
      int  t;
      bit  seen;
      wait_cfg = waits;
      t = 0;
      while (!cmd_ready && t < 20) begin tick(); t++; end
      check("ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
      check("setup_phase", {PSEL, PENABLE, cmd_ready}, 3'b100);
      check("setup_paddr", PADDR, addr);
      check("setup_pwrite", PWRITE, wr);
      if (wr) check("setup_pwdata", PWDATA, wdata);
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         tick();
         lat++;
         if (rsp_valid) seen = 1'b1;
         else check("access_phase", {PSEL, PENABLE, PWRITE, PADDR}, {2'b11, wr, addr});
      end
      check("rsp_seen", seen, 1);
      rdata = rsp_rdata;
      err   = rsp_err;
      check("idle_after_rsp", {PSEL, PENABLE, cmd_ready}, 3'b001);
      check("paddr_hold", PADDR, addr);
      tick();
      check("rsp_single_pulse", rsp_valid, 0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   initial begin
      vec_t        vec [8];
      logic [31:0] rd;
      logic        er;
      int          lat;

      vec[0] = '{1'b1, 32'h04, 32'h7,        32'h0};
      vec[1] = '{1'b0, 32'h04, 32'h0,        32'h7};
      vec[2] = '{1'b1, 32'h08, 32'hDEADBEEF, 32'h0};
      vec[3] = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF};
      vec[4] = '{1'b0, 32'h10, 32'h0,        32'h0};
      vec[5] = '{1'b1, 32'h04, 32'h55,       32'h0};
      vec[6] = '{1'b0, 32'h04, 32'h0,        32'h55};
      vec[7] = '{1'b0, 32'hFF, 32'h0,        32'h0};

      for (int i = 0; i < 256; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end
      rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", cmd_ready, 0);
      check("reset_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
      check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
      rst = 1'b1;
      tick();
      check("ready_after_release", cmd_ready, 1);

      // Directed table
      foreach (vec[i]) begin
         do_xfer(vec[i].wr, vec[i].addr, vec[i].wdata, 0, rd, er, lat);
         if (vec[i].wr) ref_mem[vec[i].addr[7:0]] = vec[i].wdata;
         check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
         check($sformatf("vec%0d_err", i), er, 0);
         check($sformatf("vec%0d_latency", i), lat, 3);
      end

      // Back-to-back writes with cmd_valid held
      begin
         int acc_t [3];
         int k;
         int low;
         int r0;
         bit acc;
         wait_cfg = 0;
         r0 = rsp_cnt; k = 0; low = 0;
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1; cmd_wdata = 32'h101;
         for (int t = 0; t < 30 && k < 3; t++) begin
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
               acc_t[k] = t;
               k++;
               if (k < 3) begin cmd_addr = 32'(k + 1); cmd_wdata = 32'h100 + 32'(k + 1); end
               else cmd_valid = 1'b0;
            end
            if (k >= 1 && k < 3 && !PSEL) low++;
         end
         check("b2b_accepts", k, 3);
         check("b2b_gap01", acc_t[1] - acc_t[0], 3);
         check("b2b_gap12", acc_t[2] - acc_t[1], 3);
         check("b2b_psel_low_cycles", low, 2);
         repeat (4) tick();
         check("b2b_responses", rsp_cnt - r0, 3);
         for (int a = 1; a <= 3; a++) ref_mem[a] = 32'h100 + 32'(a);
         do_xfer(1'b0, 32'h2, 32'h0, 0, rd, er, lat);
         check("b2b_readback", rd, 32'h102);
      end

`ifdef APB_MASTER_PREADY_EN
      // Two wait states then a stuck-low PREADY timeout
      do_xfer(1'b1, 32'h30, 32'hA5A5, 2, rd, er, lat);
      ref_mem[8'h30] = 32'hA5A5;
      check("wait_write_latency", lat, 5);
      do_xfer(1'b0, 32'h30, 32'h0, 2, rd, er, lat);
      check("wait_read_latency", lat, 5);
      check("wait_read_rdata", rd, 32'hA5A5);
      check("wait_read_err", er, 0);
      do_xfer(1'b0, 32'h30, 32'h0, 1000, rd, er, lat);
      check("timeout_latency", lat, 6);
      check("timeout_err", er, 1);
      check("timeout_rdata", rd, 0);
      do_xfer(1'b0, 32'h30, 32'h0, 0, rd, er, lat);
      check("post_timeout_rdata", rd, 32'hA5A5);
      check("post_timeout_err", er, 0);
`endif

      // Reset while in ACCESS: transfer dropped, no response
      begin
         int r0;
         wait_cfg = 0;
         r0 = rsp_cnt;
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h99;
         tick();
         cmd_valid = 1'b0;
         tick();
         check("pre_reset_access", {PSEL, PENABLE}, 2'b11);
         #2 rst = 1'b0;
         #1;
         check("async_reset_bus", {PSEL, PENABLE, PADDR}, '0);
         check("async_reset_ready", cmd_ready, 0);
         repeat (2) tick();
         check("reset_no_rsp", rsp_cnt - r0, 0);
         rst = 1'b1;
         tick();
         check("ready_after_reset", cmd_ready, 1);
         do_xfer(1'b0, 32'h4, 32'h0, 0, rd, er, lat);
         check("post_reset_read", rd, ref_mem[8'h04]);
         check("post_reset_latency", lat, 3);
         do_xfer(1'b0, 32'h20, 32'h0, 0, rd, er, lat);
         check("dropped_write_absent", rd, ref_mem[8'h20]);
      end

      // Randomized traffic against the reference memory
      for (int i = 0; i < 40; i++) begin
         bit          wr;
         logic [31:0] addr;
         logic [31:0] wd;
         logic [31:0] exp;
         int          waits;
         wr    = 1'($urandom_range(0, 1));
         addr  = 32'($urandom_range(0, 255));
         wd    = $urandom;
`ifdef APB_MASTER_PREADY_EN
         waits = int'($urandom_range(0, 2));
`else
         waits = 0;
`endif
         if (wr) begin ref_mem[addr[7:0]] = wd; exp = '0; end
         else exp = ref_mem[addr[7:0]];
         do_xfer(wr, addr, wd, waits, rd, er, lat);
         check($sformatf("rand%0d_rdata", i), rd, exp);
         check($sformatf("rand%0d_err", i), er, 0);
         check($sformatf("rand%0d_latency", i), lat, 3 + waits);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-channel APB master that turns a simple valid/ready command port into APB SETUP/ACCESS transfers and returns read data and status on a one-cycle response strobe. It sits directly upstream of the APB slave memory (`AMBA_BUS`) and drives its PADDR/PSEL/PENABLE/PWRITE/PWDATA inputs while consuming PRDATA. It replaces hand-driven bus stimulus with a reusable, protocol-correct bus driver.

## Interface
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT`, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout (used only with `APB_MASTER_PREADY_EN`)

- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  master can accept a command
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  transfer address
- `cmd_wdata`  in  DATA_W  write data, ignored for reads
- `rsp_valid`  out  1  one-cycle pulse: transfer finished
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors
- `rsp_err`  out  1  timeout abort, valid with `rsp_valid`
- `PADDR`  out  ADDR_W  APB address
- `PSEL`  out  1  APB select
- `PENABLE`  out  1  APB enable
- `PWRITE`  out  1  APB direction
- `PWDATA`  out  DATA_W  APB write data
- `PRDATA`  in  DATA_W  APB read data
- `PREADY`  in  1  APB ready (present only with `APB_MASTER_PREADY_EN`)

## Operation
- FSM states IDLE, SETUP, ACCESS.
- IDLE: `cmd_ready`=1, PSEL=0, PENABLE=0. On `cmd_valid && cmd_ready`: register addr/write/wdata onto PADDR/PWRITE/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, `cmd_ready`=0; always advances to ACCESS after one cycle.
- ACCESS: PSEL=1, PENABLE=1. Completes when PREADY=1 (or unconditionally without the macro). On completion: capture PRDATA into `rsp_rdata` if read (else 0), `rsp_err`=0, pulse `rsp_valid`, go IDLE.
- Timeout: wait counter clears on entering ACCESS, increments each ACCESS cycle with PREADY=0; when it equals `TIMEOUT` (nonzero), complete with `rsp_err`=1, `rsp_rdata`=0, go IDLE.
- PADDR/PWRITE/PWDATA hold their last value in IDLE; change only on command accept.
- `cmd_*` inputs are sampled only at accept; changes in SETUP/ACCESS are ignored.
- Reset (async, any state): state=IDLE, all outputs 0 (`cmd_ready` 0 while `rst` low, 1 from first cycle after release), counter 0, in-flight transfer dropped with no response.

## Timing
- Accept edge N -> SETUP in cycle N+1 -> ACCESS in N+2 -> zero-wait completion at edge ending N+2 -> `rsp_valid` high and IDLE in N+3.
- Each wait state adds exactly one cycle to ACCESS.
- Throughput: one transfer per 3 cycles min; `cmd_ready` and `rsp_valid` are high together in the completion-following IDLE cycle, so a new command may be accepted then.
- `rsp_valid` is a single-cycle pulse; no backpressure on the response.

## Configuration
- `APB_MASTER_PREADY_EN` defined: `PREADY` port exists, wait states honoured, `TIMEOUT` counter active.
- Undefined: no `PREADY` port, ACCESS always exactly one cycle, no counter, `rsp_err` tied 0.

## Structure
- Package `apb_pkg`: state enum (IDLE/SETUP/ACCESS), default `ADDR_W`/`DATA_W` constants, shared with the APB slave and bench.
- Sub-module `apb_wait_timer` (counter + compare, instantiated only under the macro); FSM and bus registers in the top.

## Test plan
- Write: cmd addr=0x4, wdata=7 -> PSEL rises N+1, PENABLE N+2, PADDR=0x4, PWDATA=7, PWRITE=1; `rsp_valid` at N+3, `rsp_err`=0.
- Read back: read addr=0x4 after above -> `rsp_rdata`=7 at N+3; PWRITE=0 throughout.
- Back-to-back: `cmd_valid` held with writes to 0x1, 0x2, 0x3 -> three accepts 3 cycles apart, PSEL low exactly one cycle between.
- Wait states (macro on): PREADY low 2 cycles in ACCESS -> ACCESS lasts 3 cycles, `rsp_valid` at N+5, correct data.
- Timeout (macro on, TIMEOUT=4): PREADY stuck low -> after 4 ACCESS cycles `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0, PSEL=0, next command accepted.
- Reset mid-ACCESS: `rst` low -> PSEL/PENABLE/PADDR 0 immediately, no `rsp_valid`; after release a read of 0x4 completes normally.
